// File: rtl/adc_frame_packer_if.sv
// adc_frame_packer_if: byte stream handshake toward the UART transmitter
interface adc_frame_packer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master(output tx_data, tx_valid, input tx_ready);
    modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs I/U sample pairs into 8-byte checksummed frames for the UART
module adc_frame_packer #(
    parameter int         WIDTH = 16,
    parameter logic [7:0] SYNC0 = 8'hA5,
    parameter logic [7:0] SYNC1 = 8'h5A
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 word_clk,
    input  logic [WIDTH-1:0]     data_i,
    input  logic [WIDTH-1:0]     data_u,
    adc_frame_packer_if.master   tx,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state, state_n;
    logic        wc_q, wc_edge, pend_full, load, hs, last;
    logic [15:0] ext_i, ext_u, pend_i, pend_u, frm_i, frm_u;
    logic [7:0]  seq, seq_n, frm_chk;
    logic [2:0]  idx;
    logic [63:0] frm_bytes;

    assign ext_i     = 16'(signed'(data_i));
    assign ext_u     = 16'(signed'(data_u));
    assign wc_edge   = word_clk & ~wc_q;
    assign hs        = tx.tx_valid & tx.tx_ready;
    assign last      = hs && idx == 3'd7;
    // seq as it will read after this cycle, so a back-to-back load checksums the new number
    assign seq_n     = last ? seq + 8'd1 : seq;
    assign frm_bytes = {frm_chk, frm_u[7:0], frm_u[15:8], frm_i[7:0], frm_i[15:8], seq, SYNC1, SYNC0};
    assign tx.tx_valid = state == SEND;
    assign busy        = state == SEND;
    assign tx.tx_data  = state == SEND ? frm_bytes[{idx, 3'b000} +: 8] : 8'h00;

    always_comb begin
        load    = pend_full & (state == IDLE | last);
        state_n = state == IDLE ? (pend_full ? SEND : IDLE) : (last & ~pend_full ? IDLE : SEND);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_q      <= 1'b0;
            pend_full <= 1'b0;
            pend_i    <= '0;
            pend_u    <= '0;
            frm_i     <= '0;
            frm_u     <= '0;
            frm_chk   <= '0;
            seq       <= '0;
            idx       <= '0;
            drop_cnt  <= '0;
        end else begin
            wc_q <= word_clk;
            if (wc_edge & (~pend_full | load)) begin
                pend_i    <= ext_i;
                pend_u    <= ext_u;
                pend_full <= 1'b1;
            end else if (load) begin
                pend_full <= 1'b0;
            end
            if (wc_edge & pend_full & ~load & drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (last) seq <= seq + 8'd1;
            if (load) begin
                frm_i   <= pend_i;
                frm_u   <= pend_u;
                frm_chk <= seq_n ^ pend_i[15:8] ^ pend_i[7:0] ^ pend_u[15:8] ^ pend_u[7:0];
                idx     <= '0;
            end else if (hs) begin
                idx <= idx + 3'd1;
            end
        end
    end
endmodule
